// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master/slave link.
//   spi_state_e      : master sequencer states (IDLE, SETUP, HIGH, LOW, GAP)
//   SPI_DATA_W_DEF   : default frame width in bits
//   SPI_CLK_DIV_DEF  : default system clocks per SCLK half-period
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    GAP
  } spi_state_e;

  localparam int SPI_DATA_W_DEF  = 32;
  localparam int SPI_CLK_DIV_DEF = 4;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
// Command/response handshake plus SPI pins of the SPI master.
//   i_start, i_tx_data        : command valid and word to send
//   o_ready                   : master idle, command accepted when i_start=1
//   o_rx_data, o_rx_valid     : received word and its one-cycle update strobe
//   oSPI_CLK/CS/MOSI, iSPI_MISO : SPI mode-0 pins
//   i_keep_cs                 : only with SPI_MASTER_BURST_EN, keeps CS low
//                               after the frame
// Modports: master = the spi_master_ctrl side, slave = the user/pin side.
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W_DEF
);

  logic              i_start;
  logic [DATA_W-1:0] i_tx_data;
  logic              o_ready;
  logic [DATA_W-1:0] o_rx_data;
  logic              o_rx_valid;
  logic              oSPI_CLK;
  logic              oSPI_CS;
  logic              oSPI_MOSI;
  logic              iSPI_MISO;
`ifdef SPI_MASTER_BURST_EN
  logic              i_keep_cs;
`endif

  modport master (
    input  i_start,
    input  i_tx_data,
`ifdef SPI_MASTER_BURST_EN
    input  i_keep_cs,
`endif
    input  iSPI_MISO,
    output o_ready,
    output o_rx_data,
    output o_rx_valid,
    output oSPI_CLK,
    output oSPI_CS,
    output oSPI_MOSI
  );

  modport slave (
    output i_start,
    output i_tx_data,
`ifdef SPI_MASTER_BURST_EN
    output i_keep_cs,
`endif
    output iSPI_MISO,
    input  o_ready,
    input  o_rx_data,
    input  o_rx_valid,
    input  oSPI_CLK,
    input  oSPI_CS,
    input  oSPI_MOSI
  );

endinterface

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------------------
// spi_clk_div
// Phase timer shared by every timed state of the SPI master. Counts
// 0..CLK_DIV-1 while enabled and wraps when the phase ends.
//   clk, srst  : clock, synchronous active-high reset
//   load       : restart the count at 0 (start of a frame)
//   en         : count this cycle
//   phase_done : high in the last cycle of a CLK_DIV-cycle phase
// ---------------------------------------------------------------------------
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  input  logic en,
  output logic phase_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign phase_done = en && (cnt_reg == CNT_W'(CLK_DIV - 1));

  always_comb begin
    cnt_next = cnt_reg;
    if (load || phase_done) begin
      cnt_next = '0;
    end else if (en) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// SPI mode-0 master: sends one DATA_W-bit word MSB first per command and
// captures the word returned on MISO. All outputs are registered.
//   clock_clk   : system clock (rising edge)
//   reset_reset : synchronous active-high reset
//   bus         : spi_master_ctrl_if.master (handshake + SPI pins)
// Optional feature macro: SPI_MASTER_BURST_EN (i_keep_cs holds CS low
// between frames; the next frame then starts directly with an SCLK rise).
// ---------------------------------------------------------------------------
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W_DEF,
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic             clock_clk,
  input  logic             reset_reset,
  spi_master_ctrl_if.master bus
);

  localparam int BIT_W = $clog2(DATA_W);

  spi_state_e        state_reg, state_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              keep_cs_reg, keep_cs_next;
  logic              ready_reg, ready_next;
  logic              rx_valid_reg, rx_valid_next;
  logic              sclk_reg, sclk_next;
  logic              cs_reg, cs_next;
  logic              mosi_reg, mosi_next;
  logic              keep_cs_req;
  logic              accept;
  logic              div_en;
  logic              phase_done;
  logic [DATA_W-1:0] rx_sampled;

`ifdef SPI_MASTER_BURST_EN
  assign keep_cs_req = bus.i_keep_cs;
`else
  assign keep_cs_req = 1'b0;
`endif

  assign accept     = (state_reg == IDLE) && bus.i_start;
  assign div_en     = (state_reg != IDLE);
  assign rx_sampled = {rx_shift_reg[DATA_W-2:0], bus.iSPI_MISO};

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk        (clock_clk),
    .srst       (reset_reset),
    .load       (accept),
    .en         (div_en),
    .phase_done (phase_done)
  );

  always_comb begin
    state_next    = state_reg;
    tx_shift_next = tx_shift_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    bit_cnt_next  = bit_cnt_reg;
    keep_cs_next  = keep_cs_reg;
    ready_next    = ready_reg;
    rx_valid_next = 1'b0;
    sclk_next     = sclk_reg;
    cs_next       = cs_reg;
    mosi_next     = mosi_reg;

    unique case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        // CS can only be low in IDLE after a burst frame: pre-drive the
        // next MSB so it is stable before the immediate SCLK rise.
        if (!cs_reg) begin
          mosi_next = bus.i_tx_data[DATA_W-1];
        end
        if (bus.i_start) begin
          tx_shift_next = bus.i_tx_data;
          bit_cnt_next  = BIT_W'(DATA_W - 1);
          keep_cs_next  = keep_cs_req;
          ready_next    = 1'b0;
          if (!cs_reg) begin
            state_next    = HIGH;
            sclk_next     = 1'b1;
            rx_shift_next = rx_sampled;
          end else begin
            state_next = SETUP;
            cs_next    = 1'b0;
            sclk_next  = 1'b0;
            mosi_next  = bus.i_tx_data[DATA_W-1];
          end
        end
      end

      SETUP: begin
        if (phase_done) begin
          state_next    = HIGH;
          sclk_next     = 1'b1;
          rx_shift_next = rx_sampled;
        end
      end

      HIGH: begin
        if (phase_done) begin
          state_next = LOW;
          sclk_next  = 1'b0;
          // The falling edge advances MOSI unless this was the last bit.
          if (bit_cnt_reg != '0) begin
            tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
            mosi_next     = tx_shift_reg[DATA_W-2];
          end
        end
      end

      LOW: begin
        if (phase_done) begin
          if (bit_cnt_reg == '0) begin
            rx_data_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
            if (keep_cs_reg) begin
              state_next = IDLE;
              ready_next = 1'b1;
            end else begin
              state_next = GAP;
              cs_next    = 1'b1;
              mosi_next  = 1'b0;
            end
          end else begin
            bit_cnt_next  = bit_cnt_reg - BIT_W'(1);
            state_next    = HIGH;
            sclk_next     = 1'b1;
            rx_shift_next = rx_sampled;
          end
        end
      end

      GAP: begin
        if (phase_done) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_reg    <= IDLE;
      tx_shift_reg <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      bit_cnt_reg  <= '0;
      keep_cs_reg  <= 1'b0;
      ready_reg    <= 1'b1;
      rx_valid_reg <= 1'b0;
      sclk_reg     <= 1'b0;
      cs_reg       <= 1'b1;
      mosi_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_shift_reg <= tx_shift_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      bit_cnt_reg  <= bit_cnt_next;
      keep_cs_reg  <= keep_cs_next;
      ready_reg    <= ready_next;
      rx_valid_reg <= rx_valid_next;
      sclk_reg     <= sclk_next;
      cs_reg       <= cs_next;
      mosi_reg     <= mosi_next;
    end
  end

  assign bus.o_ready    = ready_reg;
  assign bus.o_rx_data  = rx_data_reg;
  assign bus.o_rx_valid = rx_valid_reg;
  assign bus.oSPI_CLK   = sclk_reg;
  assign bus.oSPI_CS    = cs_reg;
  assign bus.oSPI_MOSI  = mosi_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
// Self-checking bench for spi_master_ctrl (default build, DATA_W=32,
// CLK_DIV=4). A mode-0 slave model answers each frame with a chosen word and
// a pin monitor records CS pulse lengths, SCLK rises, the MOSI word and
// rx_valid pulses. Expected values come from frame-level arithmetic.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

  localparam int DW        = spi_pkg::SPI_DATA_W_DEF;
  localparam int CD        = spi_pkg::SPI_CLK_DIV_DEF;
  localparam int FRAME_CS  = CD * (2 * DW + 1);     // CS low cycles per frame
  localparam int READY_LAT = 1 + FRAME_CS + CD;     // accept -> o_ready again

  logic clk = 1'b0;
  logic srst;
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_master_ctrl_if #(.DATA_W(DW)) bus();

  spi_master_ctrl #(
    .DATA_W  (DW),
    .CLK_DIV (CD)
  ) dut (
    .clock_clk   (clk),
    .reset_reset (srst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave model + pin monitor (negedge sampling) ----------
  logic [DW-1:0] slv_word;
  logic [DW-1:0] slv_cur  = '0;
  int            slv_idx  = 0;
  int            cs_pulses = 0, cs_low_run = 0, last_cs_len = 0;
  int            cs_high_run = 0, last_cs_high = 0;
  int            sclk_rises = 0, rxv_cnt = 0;
  logic [DW-1:0] mosi_cap = '0, last_rx = '0;
  logic          prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (bus.oSPI_CLK === 1'b1 && !prev_sclk) begin
      sclk_rises++;
      mosi_cap = {mosi_cap[DW-2:0], bus.oSPI_MOSI};
    end
    if (bus.oSPI_CS === 1'b0) begin
      cs_low_run++;
      if (prev_cs) begin
        last_cs_high  = cs_high_run;
        cs_high_run   = 0;
        slv_cur       = slv_word;
        slv_idx       = DW - 1;
        bus.iSPI_MISO = slv_word[DW-1];
      end else if (bus.oSPI_CLK === 1'b0 && prev_sclk && slv_idx > 0) begin
        slv_idx--;
        bus.iSPI_MISO = slv_cur[slv_idx];
      end
    end else begin
      cs_high_run++;
      if (!prev_cs) begin
        cs_pulses++;
        last_cs_len = cs_low_run;
        cs_low_run  = 0;
      end
    end
    if (bus.o_rx_valid === 1'b1) begin
      rxv_cnt++;
      last_rx = bus.o_rx_data;
    end
    prev_cs   = bus.oSPI_CS;
    prev_sclk = bus.oSPI_CLK;
  end

  // ---------------- helpers ----------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (bus.o_ready !== 1'b1 && c < 2000);
    if (bus.o_ready !== 1'b1) check({tag, "_ready_timeout"}, 64'(bus.o_ready), 64'(1));
  endtask

  // One frame: accept tx, optionally pulse i_start again at cycle inject_k,
  // scramble i_tx_data after accept, then check the whole frame.
  task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] slv,
                           input int inject_k, input string tag);
    int k, p0, r0, v0;
    wait_ready(tag);
    slv_word      = slv;
    p0            = cs_pulses;
    r0            = sclk_rises;
    v0            = rxv_cnt;
    bus.i_start   = 1'b1;
    bus.i_tx_data = tx;
    @(posedge clk);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      bus.i_start   = (k == inject_k);
      bus.i_tx_data = $urandom();
    end while (bus.o_ready !== 1'b1 && k < 1000);
    bus.i_start = 1'b0;
    check({tag, "_ready_lat"}, 64'(k), 64'(READY_LAT));
    check({tag, "_cs_pulses"}, 64'(cs_pulses - p0), 64'(1));
    check({tag, "_cs_len"}, 64'(last_cs_len), 64'(FRAME_CS));
    check({tag, "_sclk_rises"}, 64'(sclk_rises - r0), 64'(DW));
    check({tag, "_mosi_word"}, 64'(mosi_cap), 64'(tx));
    check({tag, "_rxv_count"}, 64'(rxv_cnt - v0), 64'(1));
    check({tag, "_rxv_data"}, 64'(last_rx), 64'(slv));
    check({tag, "_rx_hold"}, 64'(bus.o_rx_data), 64'(slv));
    $display("[TB] frame %s tx=%08h slave=%08h rx=%08h lat=%0d", tag, tx, slv, bus.o_rx_data, k);
  endtask

  // ---------------- directed sequence ------------------------------------
  initial begin : main
    int            p0, r0, v0, k;
    logic [DW-1:0] w_a, w_b;

    srst          = 1'b1;
    bus.i_start   = 1'b1;               // must be ignored while in reset
    bus.i_tx_data = 32'hDEAD_BEEF;
`ifdef SPI_MASTER_BURST_EN
    bus.i_keep_cs = 1'b0;
`endif
    slv_word      = '0;
    repeat (3) @(negedge clk);
    srst        = 1'b0;
    bus.i_start = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_cs", 64'(bus.oSPI_CS), 64'(1));
    check("reset_sclk", 64'(bus.oSPI_CLK), 64'(0));
    check("reset_mosi", 64'(bus.oSPI_MOSI), 64'(0));
    check("reset_ready", 64'(bus.o_ready), 64'(1));
    check("reset_rx_data", 64'(bus.o_rx_data), 64'(0));
    check("reset_no_frame", 64'(cs_pulses), 64'(0));
    check("reset_no_rxv", 64'(rxv_cnt), 64'(0));
    $display("[TB] reset idle cs=%0b sclk=%0b ready=%0b", bus.oSPI_CS, bus.oSPI_CLK, bus.o_ready);

    // Reference frame from the test plan, then random words.
    run_frame(32'hA5C3_0F81, 32'h1234_5678, 0, "ref");
    for (int i = 0; i < 3; i++) begin
      run_frame($urandom(), $urandom(), 0, $sformatf("rand%0d", i));
    end

    // i_start during bit 10 must be ignored.
    p0 = cs_pulses;
    run_frame($urandom(), $urandom(), CD + 10 * 2 * CD, "inject");
    repeat (30) @(negedge clk);
    check("inject_single_frame", 64'(cs_pulses - p0), 64'(1));
    check("inject_idle_cs", 64'(bus.oSPI_CS), 64'(1));

    // Reset while bit 5 is in its high phase.
    wait_ready("abort");
    slv_word      = $urandom();
    p0            = cs_pulses;
    v0            = rxv_cnt;
    bus.i_start   = 1'b1;
    bus.i_tx_data = $urandom();
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (CD + 5 * 2 * CD) @(negedge clk);
    check("abort_mid_cs", 64'(bus.oSPI_CS), 64'(0));
    check("abort_mid_sclk", 64'(bus.oSPI_CLK), 64'(1));
    srst = 1'b1;
    @(negedge clk);
    check("abort_cs", 64'(bus.oSPI_CS), 64'(1));
    check("abort_sclk", 64'(bus.oSPI_CLK), 64'(0));
    check("abort_mosi", 64'(bus.oSPI_MOSI), 64'(0));
    check("abort_ready", 64'(bus.o_ready), 64'(1));
    check("abort_rx_valid", 64'(bus.o_rx_valid), 64'(0));
    check("abort_rx_data", 64'(bus.o_rx_data), 64'(0));
    srst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_rxv", 64'(rxv_cnt - v0), 64'(0));
    check("abort_one_pulse", 64'(cs_pulses - p0), 64'(1));
    $display("[TB] abort cs=%0b ready=%0b rxv=%0d", bus.oSPI_CS, bus.o_ready, rxv_cnt - v0);
    run_frame(32'hFFFF_FFFF, $urandom(), 0, "after_abort");

    // Back-to-back: i_start held high across the first ready cycle.
    wait_ready("b2b");
    w_a           = $urandom();
    w_b           = $urandom();
    slv_word      = w_a;
    p0            = cs_pulses;
    r0            = sclk_rises;
    v0            = rxv_cnt;
    bus.i_start   = 1'b1;
    bus.i_tx_data = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    bus.i_tx_data = 32'h8000_0000;
    k = 1;
    repeat (3) begin
      @(negedge clk);
      k++;
    end
    slv_word = w_b;                     // first frame already latched w_a
    while (bus.o_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("b2b1_ready_lat", 64'(k), 64'(READY_LAT));
    check("b2b1_mosi_word", 64'(mosi_cap), 64'(32'h0000_0001));
    check("b2b1_rx", 64'(last_rx), 64'(w_a));
    $display("[TB] frame b2b1 tx=00000001 slave=%08h rx=%08h lat=%0d", w_a, last_rx, k);
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    k = 1;
    while (bus.o_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("b2b2_ready_lat", 64'(k), 64'(READY_LAT));
    check("b2b_cs_gap", 64'(last_cs_high), 64'(CD + 1));
    check("b2b_pulses", 64'(cs_pulses - p0), 64'(2));
    check("b2b_rises", 64'(sclk_rises - r0), 64'(2 * DW));
    check("b2b_rxv", 64'(rxv_cnt - v0), 64'(2));
    check("b2b2_mosi_word", 64'(mosi_cap), 64'(32'h8000_0000));
    check("b2b2_rx", 64'(last_rx), 64'(w_b));
    $display("[TB] frame b2b2 tx=80000000 slave=%08h rx=%08h gap=%0d", w_b, last_rx, last_cs_high);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog");
  end

endmodule
